// File: rtl/forward_scoreboard_pkg.sv
// forward_scoreboard_pkg
//   Shared types and helpers for the forwarding scoreboard.
//   - stage_ent_t : one in-flight result stage {valid, rd, wr, load}
//   - sel_w()     : width of a forwarding select for a given stage depth
//   - FWD_RF      : select value meaning "read the register file"
package forward_scoreboard_pkg;

  // rd is stored at a fixed maximum width so the struct can live in a
  // package; modules resize their REG_W-wide addresses into it (REG_W <= 8).
  localparam int RD_W_MAX = 8;
  typedef logic [RD_W_MAX-1:0] rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic wr;
    logic load;
  } stage_ent_t;

  localparam int FWD_RF = 0;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // An entry can supply or block an operand only if it really writes a
  // non-zero-register destination.
  function automatic logic ent_live(input stage_ent_t e, input rd_t zero_reg);
    return e.valid && e.wr && (e.rd != zero_reg);
  endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// fwd_match
//   Youngest-match priority search for one source operand.
//   Ports:
//     ent_i       : all tracked stage entries (index 0 = youngest)
//     addr_i      : source register address
//     used_i      : operand is actually read
//     sel_o       : 0 = register file, k+1 = forward from stage k
//     load_hit0_o : youngest match is a load still in stage 0 (load-use)
module fwd_match
  import forward_scoreboard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31,
  parameter int SEL_W    = sel_w(DEPTH)
) (
  input  stage_ent_t [DEPTH-1:0] ent_i,
  input  logic [REG_W-1:0]       addr_i,
  input  logic                   used_i,
  output logic [SEL_W-1:0]       sel_o,
  output logic                   load_hit0_o
);

  rd_t addr;
  assign addr = rd_t'(addr_i);

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel_o       = SEL_W'(FWD_RF);
    load_hit0_o = 1'b0;
    if (used_i && (addr != rd_t'(ZERO_REG))) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_live(ent_i[k], rd_t'(ZERO_REG)) && (ent_i[k].rd == addr)) begin
          // A load in stage 0 has no result yet: read nothing, stall instead.
          if (k == 0 && ent_i[k].load) begin
            sel_o       = SEL_W'(FWD_RF);
            load_hit0_o = 1'b1;
          end else begin
            sel_o       = SEL_W'(k + 1);
            load_hit0_o = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard
//   Tracks destination registers of in-flight instructions and steers each
//   decode source operand to the register file or a forwarding stage.
//   Detects load-use hazards and stalls decode for one cycle.
//   Ports:
//     clk, reset           : clock, synchronous active-high reset
//     issue_valid/rd/wr/load: decode instruction's destination info
//     src_addr, src_used   : NSRC source addresses and read qualifiers
//     flush                : drop all tracked entries
//     fwd_sel              : per-source select (0 = RF, k+1 = stage k)
//     stall                : hold decode, insert bubble
//     stall_count          : saturating count of stall cycles
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int          REG_W     = 5,
  parameter int          DEPTH     = 2,
  parameter int          NSRC      = 3,
  parameter int          ZERO_REG  = 31,
  parameter logic [15:0] STALL_SAT = 16'hFFFF,
  localparam int         SEL_W     = sel_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic                       issue_wr,
  input  logic                       issue_load,
  input  logic [NSRC-1:0][REG_W-1:0] src_addr,
  input  logic [NSRC-1:0]            src_used,
  input  logic                       flush,
  output logic [NSRC-1:0][SEL_W-1:0] fwd_sel,
  output logic                       stall,
  output logic [15:0]                stall_count
);

  stage_ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [NSRC-1:0]        load_hit;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .REG_W   (REG_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .SEL_W   (SEL_W)
    ) u_match (
      .ent_i      (ent_q),
      .addr_i     (src_addr[i]),
      .used_i     (src_used[i]),
      .sel_o      (fwd_sel[i]),
      .load_hit0_o(load_hit[i])
    );
  end

  // Flush and reset both kill the hazard in the cycle they are asserted.
  assign stall = !reset && !flush && issue_valid && (|load_hit);

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) ent_d[k] = ent_q[k-1];
      ent_d[0] = '0;
      if (!stall) begin
        ent_d[0].valid = issue_valid;
        ent_d[0].rd    = rd_t'(issue_rd);
        ent_d[0].wr    = issue_wr;
        ent_d[0].load  = issue_load;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != STALL_SAT)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

  localparam logic [15:0] SAT = 16'd40;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_wr, issue_load, flush;
  logic [4:0]      issue_rd;
  logic [2:0][4:0] src_addr;
  logic [2:0]      src_used;
  logic [2:0][1:0] fwd_sel;
  logic            stall;
  logic [15:0]     stall_count;

  forward_scoreboard #(.REG_W(5), .DEPTH(2), .NSRC(3), .ZERO_REG(31), .STALL_SAT(SAT)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wr(issue_wr), .issue_load(issue_load), .src_addr(src_addr),
    .src_used(src_used), .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: a list of the last two issued slots, youngest first.
  typedef struct {bit v; bit [4:0] rd; bit wr; bit ld;} ment_t;
  ment_t pipe[$];
  int    m_cnt;
  ment_t blank = '{0, 0, 0, 0};

  // Last observed values, for directed spot checks.
  logic [2:0][1:0] o_sel;
  logic            o_stall;
  logic [15:0]     o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_sel(input bit [4:0] a, input bit used);
    if (!used || a == 5'd31) return 0;
    for (int k = 0; k < pipe.size(); k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd != 5'd31 && pipe[k].rd == a)
        return (k == 0 && pipe[k].ld) ? 0 : k + 1;
    return 0;
  endfunction

  function automatic bit m_stall(input bit iv, input bit fl, input bit rs,
                                 input bit [2:0][4:0] sa, input bit [2:0] su);
    if (rs || fl || !iv) return 0;
    for (int i = 0; i < 3; i++)
      if (su[i] && sa[i] != 5'd31 && pipe[0].v && pipe[0].wr && pipe[0].ld &&
          pipe[0].rd != 5'd31 && pipe[0].rd == sa[i]) return 1;
    return 0;
  endfunction

  task automatic step(input bit iv, input bit [4:0] rd, input bit wr, input bit ld,
                      input bit [2:0][4:0] sa, input bit [2:0] su,
                      input bit fl, input bit rs);
    bit    es;
    ment_t ne;
    issue_valid = iv; issue_rd = rd; issue_wr = wr; issue_load = ld;
    src_addr = sa; src_used = su; flush = fl; reset = rs;
    @(negedge clk);
    es = m_stall(iv, fl, rs, sa, su);
    o_sel = fwd_sel; o_stall = stall; o_cnt = stall_count;
    for (int i = 0; i < 3; i++) chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i]), 32'(m_sel(sa[i], su[i])));
    chk("stall", 32'(stall), 32'(es));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
    if (rs) begin
      pipe = '{blank, blank}; m_cnt = 0;
    end else begin
      if (fl) pipe = '{blank, blank};
      else begin
        ne = es ? blank : '{iv, rd, wr, ld};
        pipe.push_front(ne);
        void'(pipe.pop_back());
      end
      if (es && m_cnt < int'(SAT)) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  function automatic bit [2:0][4:0] s3(input bit [4:0] a0, input bit [4:0] a1, input bit [4:0] a2);
    return {a2, a1, a0};
  endfunction

  initial begin
    // Initial reset edge without checks; outputs are unknown before it.
    reset = 1; issue_valid = 0; issue_rd = 0; issue_wr = 0; issue_load = 0;
    src_addr = '0; src_used = '0; flush = 0;
    pipe = '{blank, blank}; m_cnt = 0;
    @(posedge clk); #1;

    // Reset state: with sources used, nothing forwards, no stall.
    step(1, 5'd1, 1, 1, s3(1, 2, 3), 3'b111, 0, 1);
    chk("reset_cnt", 32'(o_cnt), 0);

    // ALU result forwarded from stage 0.
    step(1, 5'd1, 1, 0, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(1, 0, 0), 3'b001, 0, 0);
    chk("alu_fwd_sel", 32'(o_sel[0]), 1);
    chk("alu_fwd_stall", 32'(o_stall), 0);

    // Two writers of X2: youngest wins.
    step(1, 5'd2, 1, 0, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd2, 1, 0, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(2, 2, 0), 3'b011, 0, 0);
    chk("youngest_sel0", 32'(o_sel[0]), 1);
    chk("youngest_sel1", 32'(o_sel[1]), 1);

    // Load-use: one stall cycle, then forward from stage 1.
    step(1, 5'd3, 1, 1, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(3, 0, 0), 3'b001, 0, 0);
    chk("lu_stall", 32'(o_stall), 1);
    chk("lu_sel_stall", 32'(o_sel[0]), 0);
    step(1, 5'd9, 0, 0, s3(3, 0, 0), 3'b001, 0, 0);
    chk("lu_stall_after", 32'(o_stall), 0);
    chk("lu_sel_after", 32'(o_sel[0]), 2);
    chk("lu_count", 32'(o_cnt), 1);

    // X31 never forwarded; unused source never forwarded.
    step(1, 5'd31, 1, 0, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(31, 0, 0), 3'b001, 0, 0);
    chk("zero_reg_sel", 32'(o_sel[0]), 0);
    chk("zero_reg_stall", 32'(o_stall), 0);
    step(1, 5'd4, 1, 0, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(4, 4, 0), 3'b010, 0, 0);
    chk("unused_sel", 32'(o_sel[0]), 0);
    chk("used_sel", 32'(o_sel[1]), 1);

    // Flush kills a pending load-use hazard and all entries.
    step(1, 5'd5, 1, 1, s3(0, 0, 0), 3'b000, 0, 0);
    step(1, 5'd9, 0, 0, s3(5, 5, 5), 3'b111, 1, 0);
    chk("flush_stall", 32'(o_stall), 0);
    step(1, 5'd9, 0, 0, s3(5, 5, 5), 3'b111, 0, 0);
    chk("post_flush_sel", 32'(o_sel), 0);

    // Randomized traffic against the reference list.
    for (int n = 0; n < 400; n++) begin
      bit [4:0] r, a0, a1, a2;
      r  = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
      a0 = ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
      a1 = 5'($urandom_range(0, 5));
      a2 = 5'($urandom_range(0, 5));
      step(1'($urandom), r, 1'($urandom), 1'($urandom), s3(a0, a1, a2),
           3'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    // Saturate the counter with back-to-back load-use pairs, then reset.
    step(0, 5'd0, 0, 0, s3(0, 0, 0), 3'b000, 0, 1);
    for (int n = 0; n < 2 * (int'(SAT) + 5); n++)
      step(1, 5'd3, 1, 1, s3(3, 0, 0), 3'b001, 0, 0);
    step(0, 5'd0, 0, 0, s3(0, 0, 0), 3'b000, 0, 0);
    chk("sat_count", 32'(o_cnt), 32'(SAT));
    step(1, 5'd3, 1, 1, s3(3, 3, 3), 3'b111, 0, 1);
    step(1, 5'd9, 0, 0, s3(3, 3, 3), 3'b111, 0, 1);
    chk("reset_clears_cnt", 32'(o_cnt), 0);
    chk("reset_clears_sel", 32'(o_sel), 0);
    chk("reset_no_stall", 32'(o_stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter REG_W, 5, register-address width.
REQ-002 Parameter DEPTH, 2, number of in-flight result stages tracked (stage 0 = ALU, stage DEPTH-1 = oldest).
REQ-003 Parameter NSRC, 3, number of source operands checked per cycle.
REQ-004 Parameter ZERO_REG, 31, register index never forwarded and never hazarded.
REQ-005 Port clk input 1: single clock, all state updates on rising edge.
REQ-006 Port reset input 1: synchronous, active-high reset.
REQ-007 Port issue_valid input 1: instruction in decode presents operands this cycle.
REQ-008 Port issue_rd input REG_W: destination register of decode instruction.
REQ-009 Port issue_wr input 1: decode instruction writes issue_rd.
REQ-010 Port issue_load input 1: decode instruction's result exists only from stage 1 onward.
REQ-011 Port src_addr input NSRC x REG_W: source register addresses.
REQ-012 Port src_used input NSRC: per-source "operand actually read" qualifier.
REQ-013 Port flush input 1: discard all tracked entries.
REQ-014 Port fwd_sel output NSRC x SEL_W, SEL_W = clog2(DEPTH+1): 0 = register file, k+1 = stage k.
REQ-015 Port stall output 1: hold decode, insert bubble.
REQ-016 Port stall_count output 16: saturating count of stall cycles.

Function
REQ-017 Each stage entry holds {valid, rd, wr, load}; an entry is live when valid and wr and rd != ZERO_REG.
REQ-018 fwd_sel[i] is combinational from current entries and src_addr/src_used; zero latency.
REQ-019 fwd_sel[i] = k+1 for the smallest k with a live entry whose rd == src_addr[i]; youngest match wins over older matches.
REQ-020 fwd_sel[i] = 0 when src_used[i] = 0, src_addr[i] = ZERO_REG, or no live match.
REQ-021 stall = 1 when issue_valid and any used source matches a live stage-0 entry with load = 1 (load-use).
REQ-022 A stage-0 load match yields fwd_sel[i] = 0 while stall is asserted; no forwarding from a load in stage 0.
REQ-023 On each clock, entry k moves to k+1 for all k < DEPTH-1; entry DEPTH-1 retires.
REQ-024 On a clock with stall = 0, stage 0 loads {issue_valid, issue_rd, issue_wr, issue_load}.
REQ-025 On a clock with stall = 1, stage 0 loads a bubble (valid = 0); older stages still advance.
REQ-026 After one stall cycle, the load sits in stage 1, so the same decode instruction then receives fwd_sel = 2 with stall = 0; a load never causes more than one consecutive stall.
REQ-027 flush = 1 clears every entry valid on the next edge and forces stall = 0 in the same cycle; flush takes precedence over issue capture.
REQ-028 stall_count increments by 1 on each edge where stall = 1, saturating at 16'hFFFF; flush does not clear it.
REQ-029 Multiple sources matching the same or different stages are resolved independently per source.

Reset
REQ-030 On reset, all entries become valid = 0, rd = 0, wr = 0, load = 0; stall_count = 0.
REQ-031 With reset asserted, stall = 0 and all fwd_sel = 0 from the cycle after the reset edge.
REQ-032 Reset overrides flush, stall and issue capture; reset mid-stall discards the bubble and the held instruction's hazard.

Structure
REQ-033 A shared package holds the stage-entry struct typedef, SEL_W computation and the FWD_RF = 0 select encoding.
REQ-034 One sub-module, fwd_match, SHALL implement the per-source youngest-match priority search and be instantiated NSRC times.

Verification
REQ-035 ADD X1 issued, next cycle ADD reading X1 on src 0 -> fwd_sel[0] = 1, stall = 0.
REQ-036 ADD X2 then ADD X2 then reader of X2 -> fwd_sel = 1 (youngest), not 2.
REQ-037 LDUR X3 then reader of X3 -> stall = 1 one cycle, fwd_sel = 0; next cycle stall = 0, fwd_sel = 2; stall_count = 1.
REQ-038 Writer of X31 then reader of X31 -> fwd_sel = 0, stall = 0; writer of X4 with src_used = 0 on reader -> fwd_sel = 0.
REQ-039 LDUR X5 issued, flush asserted next cycle alongside reader of X5 -> stall = 0, then all fwd_sel = 0 after the edge.
REQ-040 Force 65537 load-use stalls -> stall_count = 16'hFFFF; assert reset -> stall_count = 0, entries empty.
